// File: rtl/ps2_keyboard_interface.sv
// PS/2 device-to-host receiver with glitch filtering, frame timeout, and
// make/break/extended/shift tracking that translates a key subset to ASCII.
module ps2_keyboard_interface #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [15:0] Key_Data,
  output logic        Keypress,
  output logic        Frame_Error,
  output logic [7:0]  Scancode_Out
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_e;

  logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic          clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  logic          clk_prev_q, clk_prev_d;
  logic          fall;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_ok, frame_err;

  logic [15:0]   key_data_q, key_data_d;
  logic          keypress_q, keypress_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    sc_q, sc_d;
  logic          shift_q, shift_d, brk_q, brk_d, ext_q, ext_d;
  logic [7:0]    ascii;

  // Lowercase/digit/control mapping; shift only uppercases letters.
  function automatic logic [7:0] translate(input logic [7:0] b, input logic sh);
    logic [7:0] a;
    case (b)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";  8'h25: a = "4";
      8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";  8'h3E: a = "8";
      8'h46: a = "9";  8'h45: a = "0";
      8'h29: a = 8'h20; 8'h5A: a = 8'h0A; 8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    if (sh && a >= "a" && a <= "z") a = a - 8'h20;
    return a;
  endfunction

  // A filtered level changes only after FILTER_LEN consecutive differing samples.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], PS2_CLK};
    dat_sync_d = {dat_sync_q[0], PS2_DAT};
    clk_filt_d = clk_filt_q;
    dat_filt_d = dat_filt_q;
    clk_cnt_d  = '0;
    dat_cnt_d  = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_cnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
      else                                  clk_cnt_d  = clk_cnt_q + 1'b1;
    end
    if (dat_sync_q[1] != dat_filt_q) begin
      if (dat_cnt_q == FW'(FILTER_LEN - 1)) dat_filt_d = dat_sync_q[1];
      else                                  dat_cnt_d  = dat_cnt_q + 1'b1;
    end
    clk_prev_d = clk_filt_q;
  end

  assign fall = clk_prev_q & ~clk_filt_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    to_cnt_d  = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
    if (state_q != S_IDLE && !fall && to_cnt_q == TW'(TIMEOUT - 1)) begin
      state_d   = S_IDLE;
      frame_err = 1'b1;
      to_cnt_d  = '0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_filt_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shreg_d   = {dat_filt_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_filt_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (dat_filt_q && ^{shreg_q, par_q}) frame_ok  = 1'b1;
          else                                 frame_err = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ascii = translate(shreg_q, shift_q);

  always_comb begin
    key_data_d = key_data_q;
    keypress_d = 1'b0;
    ferr_d     = frame_err;
    sc_d       = sc_q;
    shift_d    = shift_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    if (frame_err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
    if (frame_ok) begin
      sc_d = shreg_q;
      if (shreg_q == 8'hE0) ext_d = 1'b1;
      else if (shreg_q == 8'hF0) brk_d = 1'b1;
      else begin
        if (shreg_q == 8'h12 || shreg_q == 8'h59) shift_d = ~brk_q;
        else if (!brk_q && !ext_q && ascii != 8'h00) begin
          key_data_d = {8'h00, ascii};
          keypress_d = 1'b1;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      key_data_q <= '0;
      keypress_q <= 1'b0;
      ferr_q     <= 1'b0;
      sc_q       <= '0;
      shift_q    <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_filt_q <= clk_filt_d;
      dat_filt_q <= dat_filt_d;
      clk_cnt_q  <= clk_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      key_data_q <= key_data_d;
      keypress_q <= keypress_d;
      ferr_q     <= ferr_d;
      sc_q       <= sc_d;
      shift_q    <= shift_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
    end
  end

  assign Key_Data     = key_data_q;
  assign Keypress     = keypress_q;
  assign Frame_Error  = ferr_q;
  assign Scancode_Out = sc_q;

endmodule

// File: tb/tb_ps2_keyboard_interface.sv
// Directed bench for ps2_keyboard_interface: PS/2 frames driven bit by bit,
// a table-driven keyboard model feeding expected strobes and frame errors.
module tb_ps2_keyboard_interface;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [15:0] key_data;
  logic        keypress;
  logic        frame_error;
  logic [7:0]  scancode_out;

  ps2_keyboard_interface #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .Clk(clk), .Reset(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .Key_Data(key_data), .Keypress(keypress), .Frame_Error(frame_error),
    .Scancode_Out(scancode_out)
  );

  // clock/reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // keyboard model
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45};

  logic [15:0] exp_q[$];
  int          exp_err = 0;
  logic        m_shift = 1'b0, m_brk = 1'b0, m_ext = 1'b0;
  logic [7:0]  exp_sc = 8'h00;
  logic [15:0] cur_kd = 16'h0000;
  int          nstrobes = 0;
  int          err_cyc = 0;
  int          last_fall_cyc = 0;

  function automatic logic [7:0] model_ascii(input logic [7:0] b, input logic sh);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == b) return (sh ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == b) return (i == 9) ? 8'h30 : 8'h31 + 8'(i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0A;
    if (b == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_frame(input logic [7:0] b);
    logic [7:0] a;
    exp_sc = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      a = model_ascii(b, m_shift);
      if (b == 8'h12 || b == 8'h59) m_shift = ~m_brk;
      else if (!m_brk && !m_ext && a != 8'h00) exp_q.push_back({8'h00, a});
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_err = 0;
    m_shift = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    exp_sc = 8'h00;
    cur_kd = 16'h0000;
  endtask

  // driver: nbits < 11 sends a truncated frame
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit glitch);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    if (nbits == 11) begin
      if (bad_par) begin
        exp_err++;
        m_brk = 1'b0;
        m_ext = 1'b0;
      end else model_frame(b);
    end
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (15) @(negedge clk);
      if (glitch && i == 4) begin
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (12) @(negedge clk);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    ps2_dat = 1'b1;
    repeat (30) @(negedge clk);
    if (nbits == 11) begin
      chk("strobes_drained", exp_q.size(), 0);
      chk("errors_drained", exp_err, 0);
      chk("scancode", scancode_out, exp_sc);
    end
  endtask

  // scoreboard: checks outputs against the model every cycle out of reset
  logic [15:0] e_kd;
  always @(negedge clk) begin
    if (rst_n) begin
      if (keypress) begin
        nstrobes++;
        if (exp_q.size() == 0) chk("unexpected_keypress", {16'h0, key_data}, 32'hFFFF_FFFF);
        else begin
          e_kd = exp_q.pop_front();
          cur_kd = e_kd;
          chk("keypress_data", key_data, e_kd);
        end
      end else begin
        chk("key_data_hold", key_data, cur_kd);
      end
      if (frame_error) begin
        err_cyc = cyc;
        if (exp_err == 0) chk("unexpected_frame_error", 1, 0);
        else exp_err--;
      end
    end
  end

  int s0;

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_key_data", key_data, 16'h0000);
    chk("reset_keypress", keypress, 0);
    chk("reset_frame_error", frame_error, 0);
    chk("reset_scancode", scancode_out, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'h1C, 0, 11, 0);
    chk("lit_a_key", key_data, 16'h0061);
    chk("lit_a_sc", scancode_out, 8'h1C);

    s0 = nstrobes;
    send_frame(8'h12, 0, 11, 0);
    send_frame(8'h1C, 0, 11, 0);
    chk("lit_shift_A", key_data, 16'h0041);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h1C, 0, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h12, 0, 11, 0);
    send_frame(8'h1C, 0, 11, 0);
    chk("lit_unshift_a", key_data, 16'h0061);
    chk("lit_two_strobes", nstrobes - s0, 2);

    send_frame(8'h1C, 1, 11, 0);
    chk("lit_parity_hold", key_data, 16'h0061);
    send_frame(8'h29, 0, 11, 0);
    chk("lit_space", key_data, 16'h0020);

    send_frame(8'h5A, 0, 5, 0);
    exp_err++;
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (TIMEOUT + 40) @(negedge clk);
    chk("timeout_error_seen", exp_err, 0);
    chk("timeout_latency_ok",
        (err_cyc - last_fall_cyc >= TIMEOUT) && (err_cyc - last_fall_cyc <= TIMEOUT + 25), 1);
    send_frame(8'h5A, 0, 11, 0);
    chk("lit_enter", key_data, 16'h000A);

    s0 = nstrobes;
    send_frame(8'hE0, 0, 11, 0);
    send_frame(8'h75, 0, 11, 0);
    send_frame(8'h05, 0, 11, 0);
    chk("lit_f1_sc", scancode_out, 8'h05);
    chk("lit_ext_hold", key_data, 16'h000A);
    chk("lit_no_ext_strobe", nstrobes - s0, 0);

    send_frame(8'hE0, 0, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h75, 0, 11, 0);
    s0 = nstrobes;
    send_frame(8'h66, 0, 11, 0);
    send_frame(8'h66, 0, 11, 0);
    chk("lit_backspace_repeat", nstrobes - s0, 2);
    chk("lit_backspace", key_data, 16'h0008);
    send_frame(8'h59, 0, 11, 0);
    send_frame(8'h45, 0, 11, 0);
    chk("lit_digit_shift", key_data, 16'h0030);
    send_frame(8'h1A, 0, 11, 0);
    chk("lit_rshift_Z", key_data, 16'h005A);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h59, 0, 11, 0);

    send_frame(8'h32, 0, 11, 1);
    chk("lit_glitch_b", key_data, 16'h0062);

    send_frame(8'h16, 0, 6, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("midreset_key_data", key_data, 16'h0000);
    chk("midreset_keypress", keypress, 0);
    chk("midreset_frame_error", frame_error, 0);
    chk("midreset_scancode", scancode_out, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h16, 0, 11, 0);
    chk("lit_digit_1", key_data, 16'h0031);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
